// File: rtl/led_fader_if.sv
// LED fader signal bundle: requested level in, PWM drive and status out.
// The master side (blink stage / bench) drives led_i; the slave side is the fader.
interface led_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                led_i;
    logic                led_o;
    logic [PWM_BITS-1:0] level_o;
    logic                busy_o;

    modport master (output led_i, input led_o, level_o, busy_o);
    modport slave  (input led_i, output led_o, level_o, busy_o);
endinterface

// File: rtl/led_fader.sv
// LED fader: PWM driver whose duty level follows led_i.
// With LED_FADER_FADE_EN defined the level ramps one step per PWM frame
// (states OFF/RISE/ON/FALL); otherwise it jumps straight to the on/off level
// at the next frame boundary and busy_o is tied low.
// Levels only ever change on the tick that wraps the PWM counter, so a frame
// is always rendered with a single duty value.
module led_fader #(
    parameter int FREQ     = 50000000,
    parameter int PWM_HZ   = 1000,
    parameter int PWM_BITS = 8,
    parameter int DUTY_MAX = 255
) (
    input  logic     clk_i,
    input  logic     rst_i,
    led_fader_if.slave bus
);
    localparam int DIV_RAW  = FREQ / (PWM_HZ * (1 << PWM_BITS));
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LVL_TOP  = (1 << PWM_BITS) - 1;
    localparam int DUTY_CLP = (DUTY_MAX > LVL_TOP) ? LVL_TOP : DUTY_MAX;

    localparam logic [PRE_W-1:0]    DIV_LAST = PRE_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY     = PWM_BITS'(DUTY_CLP);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

`ifdef LED_FADER_FADE_EN
    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;
`else
    typedef enum logic {OFF, ON} state_t;
`endif

    logic [PRE_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic                led;
    state_t              state;
    state_t              state_next;
    logic                tick;
    logic                frame_end;

    assign tick      = (presc == DIV_LAST);
    assign frame_end = tick && (pwm_cnt == CNT_LAST);

    // Prescaler and free-running PWM counter.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end else begin
            presc   <= presc + PRE_W'(1);
        end
    end

    // Fade controller state and duty level register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= OFF;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

`ifdef LED_FADER_FADE_EN
    // Direction follows led_i immediately; the level moves one step toward the
    // target on each frame boundary, and the FSM rests once the target is hit.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        level_next = level;
        case (state)
            OFF:  if (bus.led_i)  state_next = RISE;
            RISE: if (!bus.led_i) state_next = FALL;
            ON:   if (!bus.led_i) state_next = FALL;
            FALL: if (bus.led_i)  state_next = RISE;
            default: state_next = OFF;
        endcase
        if (frame_end) begin
            if (bus.led_i && level != DUTY)
                level_next = level + PWM_BITS'(1);
            else if (!bus.led_i && level != '0)
                level_next = level - PWM_BITS'(1);
        end
        // Entering the end level settles the FSM in the same cycle.
        if (bus.led_i && level_next == DUTY)
            state_next = ON;
        else if (!bus.led_i && level_next == '0)
            state_next = OFF;
    end

    assign bus.busy_o = (state == RISE) || (state == FALL);
`else
    // On/off only: the requested state is adopted at the next frame boundary
    // and the level jumps straight to its end value.
    always_comb begin
        state_next = state;
        level_next = level;
        case (state)
            OFF:     if (frame_end && bus.led_i)  state_next = ON;
            ON:      if (frame_end && !bus.led_i) state_next = OFF;
            default: state_next = OFF;
        endcase
        if (frame_end)
            level_next = (state_next == ON) ? DUTY : '0;
    end

    assign bus.busy_o = 1'b0;
`endif

    // Registered PWM compare; level 0 can never satisfy it, so the LED stays dark.
    always_ff @(posedge clk_i) begin
        if (rst_i) led <= 1'b0;
        else       led <= (pwm_cnt < level);
    end

    assign bus.led_o   = led;
    assign bus.level_o = level;
endmodule
